// File: rtl/fp_result_pkg.sv
// Shared constants for the FP result collector: IEEE-754 single field
// positions and the class codes attached to each buffered result.
package fp_result_pkg;

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'd0,
        CLS_ZERO   = 3'd1,
        CLS_INF    = 3'd2,
        CLS_NAN    = 3'd3,
        CLS_SUBN   = 3'd4
    } fp_class_e;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MAN_MSB = 22;

    localparam logic [7:0] EXP_ALL1 = 8'hFF;

    // Statistics counter slots
    localparam int STAT_TOTAL = 0;
    localparam int STAT_NAN   = 1;
    localparam int STAT_INF   = 2;
    localparam int STAT_ZERO  = 3;
    localparam int STAT_SUBN  = 4;
    localparam int STAT_NUM   = 5;

endpackage

// File: rtl/fp_result_collector_classify.sv
// Combinational IEEE-754 single classifier; sign is irrelevant to the
// class so it is deliberately left unused.
module fp_classify
    import fp_result_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] tdata,
    output logic [2:0]        cls
);

    logic [7:0] exp_field;
    logic       man_zero;
    logic       unused_sign;

    assign exp_field   = tdata[EXP_MSB:EXP_LSB];
    assign man_zero    = (tdata[MAN_MSB:0] == '0);
    assign unused_sign = tdata[DATA_W-1];

    always_comb begin
        cls = CLS_NORMAL;
        unique case (1'b1)
            (exp_field == EXP_ALL1) && !man_zero: cls = CLS_NAN;
            (exp_field == EXP_ALL1) &&  man_zero: cls = CLS_INF;
            (exp_field == 8'h00)    &&  man_zero: cls = CLS_ZERO;
            (exp_field == 8'h00)    && !man_zero: cls = CLS_SUBN;
            default:                              cls = CLS_NORMAL;
        endcase
    end

endmodule

// File: rtl/fp_result_collector.sv
// AXI-Stream sink for divide results: classifies each beat, buffers it in
// a FWFT FIFO with its class tag, and keeps saturating class statistics.
module fp_result_collector
    import fp_result_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          s_axis_result_tdata,
    input  logic                       s_axis_result_tvalid,
    output logic                       s_axis_result_tready,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [2:0]                 rd_class,
    output logic [$clog2(DEPTH):0]     fifo_count,
    input  logic                       clr_stats,
    output logic [CNT_W-1:0]           cnt_total,
    output logic [CNT_W-1:0]           cnt_nan,
    output logic [CNT_W-1:0]           cnt_inf,
    output logic [CNT_W-1:0]           cnt_zero,
    output logic [CNT_W-1:0]           cnt_subn
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DATA_W+2:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [2:0]        cls;
    logic              accept;
    logic              pop;
    logic [STAT_NUM-1:0] inc;
    logic [CNT_W-1:0]  stats [STAT_NUM];

    fp_classify #(
        .DATA_W (DATA_W)
    ) u_classify (
        .tdata (s_axis_result_tdata),
        .cls   (cls)
    );

    // No bypass when full: tready looks only at the registered count
    assign s_axis_result_tready = !rst && (count != FULL);
    assign accept = s_axis_result_tvalid && s_axis_result_tready;
    assign rd_valid = (count != '0);
    assign pop = rd_en && rd_valid;

    assign {rd_class, rd_data} = mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {cls, s_axis_result_tdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        inc             = '0;
        inc[STAT_TOTAL] = accept;
        inc[STAT_NAN]   = accept && (cls == CLS_NAN);
        inc[STAT_INF]   = accept && (cls == CLS_INF);
        inc[STAT_ZERO]  = accept && (cls == CLS_ZERO);
        inc[STAT_SUBN]  = accept && (cls == CLS_SUBN);
    end

    // Clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAT_NUM; i++) begin
                stats[i] <= '0;
            end
        end else if (clr_stats) begin
            for (int i = 0; i < STAT_NUM; i++) begin
                stats[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAT_NUM; i++) begin
                if (inc[i] && (stats[i] != '1)) begin
                    stats[i] <= stats[i] + CNT_W'(1);
                end
            end
        end
    end

    assign cnt_total = stats[STAT_TOTAL];
    assign cnt_nan   = stats[STAT_NAN];
    assign cnt_inf   = stats[STAT_INF];
    assign cnt_zero  = stats[STAT_ZERO];
    assign cnt_subn  = stats[STAT_SUBN];

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector: ordering, backpressure, wrap,
// stats clear/saturation and asynchronous reset.
module tb_fp_result_collector;

    logic        clk;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [2:0]  rd_class;
    logic [3:0]  fifo_count;
    logic        clr_stats;
    logic [15:0] cnt_total;
    logic [15:0] cnt_nan;
    logic [15:0] cnt_inf;
    logic [15:0] cnt_zero;
    logic [15:0] cnt_subn;

    logic [31:0] tdata2;
    logic        tvalid2;
    logic        tready2;
    logic        rd_en2;
    logic        rd_valid2;
    logic [31:0] rd_data2;
    logic [2:0]  rd_class2;
    logic [3:0]  fifo_count2;
    logic [3:0]  cnt_total2;
    logic [3:0]  cnt_nan2;
    logic [3:0]  cnt_inf2;
    logic [3:0]  cnt_zero2;
    logic [3:0]  cnt_subn2;

    int checks = 0;
    int errors = 0;

    fp_result_collector dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_axis_result_tdata  (tdata),
        .s_axis_result_tvalid (tvalid),
        .s_axis_result_tready (tready),
        .rd_en                (rd_en),
        .rd_valid             (rd_valid),
        .rd_data              (rd_data),
        .rd_class             (rd_class),
        .fifo_count           (fifo_count),
        .clr_stats            (clr_stats),
        .cnt_total            (cnt_total),
        .cnt_nan              (cnt_nan),
        .cnt_inf              (cnt_inf),
        .cnt_zero             (cnt_zero),
        .cnt_subn             (cnt_subn)
    );

    fp_result_collector #(
        .CNT_W (4)
    ) dut_sat (
        .clk                  (clk),
        .rst                  (rst),
        .s_axis_result_tdata  (tdata2),
        .s_axis_result_tvalid (tvalid2),
        .s_axis_result_tready (tready2),
        .rd_en                (rd_en2),
        .rd_valid             (rd_valid2),
        .rd_data              (rd_data2),
        .rd_class             (rd_class2),
        .fifo_count           (fifo_count2),
        .clr_stats            (1'b0),
        .cnt_total            (cnt_total2),
        .cnt_nan              (cnt_nan2),
        .cnt_inf              (cnt_inf2),
        .cnt_zero             (cnt_zero2),
        .cnt_subn             (cnt_subn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    logic [31:0] words [5];
    logic [2:0]  classes [5];

    initial begin
        words[0] = 32'h4040_0000; classes[0] = 3'd0;
        words[1] = 32'h7F80_0000; classes[1] = 3'd2;
        words[2] = 32'h7FC0_0000; classes[2] = 3'd3;
        words[3] = 32'h8000_0000; classes[3] = 3'd1;
        words[4] = 32'h0000_0001; classes[4] = 3'd4;

        rst = 1'b1;
        tdata = '0;
        tvalid = 1'b0;
        rd_en = 1'b0;
        clr_stats = 1'b0;
        tdata2 = 32'h7FC0_0000;
        tvalid2 = 1'b0;
        rd_en2 = 1'b1;
        #12;
        chk("rst_tready", 32'(tready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_total", 32'(cnt_total), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_tready", 32'(tready), 32'd1);

        // Five classes in, in order out
        tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tdata = words[i];
            tick();
            if (i == 0) begin
                chk("latency_valid", 32'(rd_valid), 32'd1);
                chk("latency_data", rd_data, 32'h4040_0000);
            end
        end
        tvalid = 1'b0;
        chk("five_count", 32'(fifo_count), 32'd5);
        chk("five_total", 32'(cnt_total), 32'd5);
        chk("five_inf", 32'(cnt_inf), 32'd1);
        chk("five_nan", 32'(cnt_nan), 32'd1);
        chk("five_zero", 32'(cnt_zero), 32'd1);
        chk("five_subn", 32'(cnt_subn), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pop%0d_data", i), rd_data, words[i]);
            chk($sformatf("pop%0d_class", i), 32'(rd_class),
                32'(classes[i]));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk("drained_count", 32'(fifo_count), 32'd0);

        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_pop_count", 32'(fifo_count), 32'd0);
        chk("empty_pop_valid", 32'(rd_valid), 32'd0);

        // Fill to DEPTH, ninth beat held until a pop frees a slot
        tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tdata = 32'h3F80_0000 + 32'(i);
            tick();
        end
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_tready", 32'(tready), 32'd0);
        tdata = 32'h3F80_0008;
        tick();
        chk("held_count", 32'(fifo_count), 32'd8);
        chk("held_tready", 32'(tready), 32'd0);
        chk("held_head", rd_data, 32'h3F80_0000);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("freed_tready", 32'(tready), 32'd1);
        chk("freed_count", 32'(fifo_count), 32'd7);
        tick();
        tvalid = 1'b0;
        chk("refill_count", 32'(fifo_count), 32'd8);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("full_pop%0d", i), rd_data,
                32'h3F80_0000 + 32'(i));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk("full_drained", 32'(fifo_count), 32'd0);

        // Streaming push+pop across the pointer wrap
        tvalid = 1'b1;
        rd_en = 1'b1;
        tdata = 32'h4100_0000;
        tick();
        chk("stream_first", 32'(fifo_count), 32'd1);
        for (int k = 1; k < 10; k++) begin
            tdata = 32'h4100_0000 + 32'(k);
            tick();
            chk($sformatf("stream%0d_count", k), 32'(fifo_count), 32'd1);
            chk($sformatf("stream%0d_data", k), rd_data,
                32'h4100_0000 + 32'(k));
        end
        tvalid = 1'b0;
        tick();
        rd_en = 1'b0;
        chk("stream_drained", 32'(fifo_count), 32'd0);
        chk("stream_total", 32'(cnt_total), 32'd24);

        // Clear beats the same-cycle increment but the beat is stored
        clr_stats = 1'b1;
        tvalid = 1'b1;
        tdata = 32'h7F80_0000;
        tick();
        clr_stats = 1'b0;
        tvalid = 1'b0;
        chk("clr_total", 32'(cnt_total), 32'd0);
        chk("clr_inf", 32'(cnt_inf), 32'd0);
        chk("clr_nan", 32'(cnt_nan), 32'd0);
        chk("clr_count", 32'(fifo_count), 32'd1);
        chk("clr_data", rd_data, 32'h7F80_0000);
        chk("clr_class", 32'(rd_class), 32'd2);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;

        // 4-bit counters saturate at 15
        tvalid2 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_mid_nan", 32'(cnt_nan2), 32'd10);
        for (int i = 0; i < 7; i++) tick();
        tvalid2 = 1'b0;
        chk("sat_nan", 32'(cnt_nan2), 32'd15);
        chk("sat_total", 32'(cnt_total2), 32'd15);

        // Asynchronous reset between edges with entries queued
        tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tdata = 32'h3F80_0000 + 32'(i);
            tick();
        end
        tvalid = 1'b0;
        chk("prerst_count", 32'(fifo_count), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_tready", 32'(tready), 32'd0);
        chk("arst_total", 32'(cnt_total), 32'd0);
        chk("arst_sat_nan", 32'(cnt_nan2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_tready", 32'(tready), 32'd1);
        tvalid = 1'b1;
        tdata = 32'h0000_0000;
        tick();
        tvalid = 1'b0;
        chk("post_valid", 32'(rd_valid), 32'd1);
        chk("post_data", rd_data, 32'h0000_0000);
        chk("post_class", 32'(rd_class), 32'd1);
        chk("post_count", 32'(fifo_count), 32'd1);
        chk("post_zero", 32'(cnt_zero), 32'd1);
        chk("post_total", 32'(cnt_total), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
AXI-Stream sink that sits directly downstream of the single-precision floating-point divide core and consumes its m_axis_result stream. Each accepted result is classified by IEEE-754 class and buffered with its class tag in a small first-word-fall-through FIFO. A simple pop interface drains the FIFO. Saturating statistics counters support on-board checking of divide behaviour (divide-by-zero, invalid, underflow).

Parameters:
DATA_W, 32, result word width; fixed IEEE-754 single layout: sign [31], exponent [30:23], mantissa [22:0].
DEPTH, 8, FIFO depth in entries; must be a power of 2 and at least 2.
CNT_W, 16, width of each statistics counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
s_axis_result_tdata  in  DATA_W  result word from the divide core.
s_axis_result_tvalid  in  1  result beat valid.
s_axis_result_tready  out  1  collector can accept a beat.
rd_en  in  1  pop request for the head entry.
rd_valid  out  1  FIFO not empty; rd_data and rd_class are valid.
rd_data  out  DATA_W  head result word (FWFT).
rd_class  out  3  head class code.
fifo_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
clr_stats  in  1  synchronous clear of all counters.
cnt_total  out  CNT_W  accepted beats.
cnt_nan  out  CNT_W  NaN results.
cnt_inf  out  CNT_W  ±infinity results.
cnt_zero  out  CNT_W  ±zero results.
cnt_subn  out  CNT_W  subnormal results.

Behaviour:
- Reset, asynchronous: write pointer, read pointer, fifo_count and all counters go to 0. rd_valid is 0. s_axis_result_tready is forced to 0 while rst is high. FIFO memory contents are not reset.
- tready is 1 exactly when rst is low and fifo_count is less than DEPTH. It is combinational from the registered count. It does not depend on rd_en, so there is no bypass when the FIFO is full.
- Accept: a beat is accepted when tvalid and tready are both 1 on a rising edge. {class, tdata} is written at the write pointer. Pointers wrap modulo DEPTH.
- Classification is combinational from tdata, on the exponent E and mantissa M:
  - E == 0xFF and M != 0: NaN, class 3.
  - E == 0xFF and M == 0: INF, class 2.
  - E == 0 and M == 0: ZERO, class 1.
  - E == 0 and M != 0: SUBN, class 4.
  - All other values: NORMAL, class 0.
  - Sign bit is ignored for classification.
- Latency: a beat accepted at edge N appears on rd_data/rd_class with rd_valid = 1 immediately after edge N, provided the FIFO was empty.
- Pop: when rd_en and rd_valid are both 1, the read pointer advances at the edge. rd_en while empty is ignored, with no pointer or count change.
- Simultaneous accept and pop: both pointers advance and fifo_count is unchanged. When full, a pop frees space and tready rises the following cycle.
- Counters:
  - On each accepted beat, cnt_total increments, plus the counter for its class. NORMAL has no dedicated counter.
  - All counters saturate at all-ones.
  - clr_stats zeroes every counter and has priority over an increment in the same cycle; that beat is not counted, but it is still stored in the FIFO.
- Reset mid-operation: in-flight FIFO contents are discarded. Upstream must see tready = 0 during reset and must hold its beat.

Decomposition:
- Package fp_result_pkg holds:
  - class codes CLS_NORMAL=0, CLS_ZERO=1, CLS_INF=2, CLS_NAN=3, CLS_SUBN=4;
  - EXP_MSB=30, EXP_LSB=23, MAN_MSB=22;
  - EXP_ALL1=8'hFF.
- One combinational sub-module, fp_classify (tdata in, 3-bit class out). It is reusable on the operand side.
- FIFO and counters stay inline.

Test Plan:
- Push 0x40400000 (6.0/2.0 = 3.0), then 0x7F800000, 0x7FC00000, 0x80000000 and 0x00000001 with rd_en=0 -> fifo_count=5. Pops return those words in order with rd_class 0, 2, 3, 1, 4. cnt_total=5 and cnt_inf, cnt_nan, cnt_zero, cnt_subn each equal 1.
- Hold tvalid=1 with 9 beats and rd_en=0, DEPTH=8 -> tready drops after the 8th accept and the 9th beat is held. One pop -> tready=1 next cycle and the 9th beat is accepted. fifo_count returns to 8.
- Continuous tvalid=1 and rd_en=1 from empty -> from the second cycle one accept and one pop every cycle, fifo_count stays 1, and pointers wrap past 7 with correct data order.
- clr_stats=1 in the same cycle as accepting 0x7F800000 -> all counters read 0 afterwards, and the FIFO holds the word with class 2.
- CNT_W=4 and 17 NaN beats -> cnt_nan and cnt_total stick at 15.
- Assert rst asynchronously, between edges, with 3 entries queued -> immediately rd_valid=0, fifo_count=0, tready=0 and counters 0. After release, tready=1 and the next beat appears correctly.
